led_pattern_sequencer: RTL

//  Upstream feeder for the board LED output stage. Plays a loadable bit pattern

---
 rtl/led_pattern_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/led_pattern_sequencer.sv
// Serial LED pattern player: loadable pattern, programmable bit period, shadow-register
// swap at pattern boundaries. Define LED_PWM_EN to add 8-bit PWM brightness dimming.
module led_pattern_sequencer #(
   parameter int unsigned              PATTERN_WIDTH   = 32,
   parameter int unsigned              TICK_DIV        = 2097152,
   parameter logic [PATTERN_WIDTH-1:0] DEFAULT_PATTERN = 32'hAF0AF0AF,
   localparam int unsigned             LEN_W           = $clog2(PATTERN_WIDTH) + 1
) (
   input  logic                     clk_16mhz,
   input  logic                     reset,
   input  logic [PATTERN_WIDTH-1:0] pattern_data,
   input  logic [LEN_W-1:0]         pattern_length,
   input  logic                     pattern_valid,
   output logic                     pattern_ready,
   input  logic                     repeat_mode,
`ifdef LED_PWM_EN
   input  logic [7:0]               brightness,
`endif
   output logic                     user_led,
   output logic                     busy,
   output logic                     wrap_pulse
);

   localparam int unsigned        BIT_W     = (PATTERN_WIDTH > 1) ? $clog2(PATTERN_WIDTH) : 1;
   localparam int unsigned        TICK_W    = $clog2(TICK_DIV);
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [LEN_W-1:0]   FULL_LEN  = LEN_W'(PATTERN_WIDTH);

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [TICK_W-1:0]        tick_q, tick_d;
   logic [BIT_W-1:0]         bit_q, bit_d;
   logic [PATTERN_WIDTH-1:0] active_q, active_d;
   logic [LEN_W-1:0]         len_q, len_d;
   logic [PATTERN_WIDTH-1:0] shadow_data_q, shadow_data_d;
   logic [LEN_W-1:0]         shadow_len_q, shadow_len_d;
   logic                     shadow_full_q, shadow_full_d;
   logic                     led_q, led_d;
   logic                     led_bit;
   logic                     led_rst_val;
   logic                     tick_end, last_bit, pattern_end, accept;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
      return (l == '0 || l > FULL_LEN) ? FULL_LEN : l;
   endfunction

`ifdef LED_PWM_EN
   logic [7:0] pwm_cnt_q;

   always_ff @(posedge clk_16mhz) begin
      if (reset) pwm_cnt_q <= '0;
      else       pwm_cnt_q <= pwm_cnt_q + 8'd1;
   end

   assign led_bit     = active_q[bit_q] && (pwm_cnt_q < brightness);
   assign led_rst_val = DEFAULT_PATTERN[0] && (brightness != 8'd0);
`else
   assign led_bit     = active_q[bit_q];
   assign led_rst_val = DEFAULT_PATTERN[0];
`endif

   assign tick_end    = (tick_q == TICK_LAST);
   assign last_bit    = (LEN_W'(bit_q) == len_q - LEN_W'(1));
   assign pattern_end = (state_q == PLAY) && tick_end && last_bit;
   // The end-of-pattern decision below reads shadow_full_q, i.e. the pre-accept shadow.
   assign accept      = pattern_valid && !shadow_full_q;

   // NOTE: every signal driven here gets its default first, so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      tick_d        = tick_q;
      bit_d         = bit_q;
      active_d      = active_q;
      len_d         = len_q;
      shadow_data_d = shadow_data_q;
      shadow_len_d  = shadow_len_q;
      shadow_full_d = shadow_full_q;
      led_d         = 1'b0;

      unique case (state_q)
         PLAY: begin
            led_d = led_bit;
            if (tick_end) begin
               tick_d = '0;
               if (last_bit) begin
                  bit_d = '0;
                  if (shadow_full_q) begin
                     active_d      = shadow_data_q;
                     len_d         = shadow_len_q;
                     shadow_full_d = 1'b0;
                  end else if (!repeat_mode) begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         IDLE: begin
            if (shadow_full_q) begin
               active_d      = shadow_data_q;
               len_d         = shadow_len_q;
               shadow_full_d = 1'b0;
               state_d       = PLAY;
               tick_d        = '0;
               bit_d         = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Commit and accept are exclusive: commit needs a full shadow, accept an empty one.
      if (accept) begin
         shadow_data_d = pattern_data;
         shadow_len_d  = clamp_len(pattern_length);
         shadow_full_d = 1'b1;
      end
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk_16mhz) begin
      if (reset) begin
         state_q       <= PLAY;
         tick_q        <= '0;
         bit_q         <= '0;
         active_q      <= DEFAULT_PATTERN;
         len_q         <= FULL_LEN;
         shadow_data_q <= '0;
         shadow_len_q  <= FULL_LEN;
         shadow_full_q <= 1'b0;
         led_q         <= led_rst_val;
      end else begin
         state_q       <= state_d;
         tick_q        <= tick_d;
         bit_q         <= bit_d;
         active_q      <= active_d;
         len_q         <= len_d;
         shadow_data_q <= shadow_data_d;
         shadow_len_q  <= shadow_len_d;
         shadow_full_q <= shadow_full_d;
         led_q         <= led_d;
      end
   end

   // Registers already hold the post-reset playback values; reset only masks the pins.
   assign user_led      = led_q && !reset;
   assign busy          = (state_q == PLAY) && !reset;
   assign wrap_pulse    = pattern_end && !reset;
   assign pattern_ready = !shadow_full_q && !reset;

endmodule
